sa_drain: RTL
=============

# sa_drain

Output drain controller for the systolic array. After the array finishes accumulating a tile, it pulses the PE result-copy strobe once, then walks the PE result shift chain row by row. Each beat is the C column results presented at the array's bottom edge, emitted on an AXI-Stream master. It sits between the array and the output DMA/stream path and is the reading end of the `r_copy`/`en_shift`/`ro` chain that the PEs write.

## Interface
Parameters:
- `R`, 4: array rows; depth of each column's shift chain, and beats per tile.
- `C`, 4: array columns; results per beat.
- `WY`, 16: result width per PE.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_done`  in  1  pulse from array controller: accumulators hold final tile results.
- `s_last`  in  1  sampled with `s_done`; this tile ends a packet.
- `s_ready`  out  1  drain idle; `s_done` is accepted only when high.
- `r_copy`  out  1  to all PEs: load accumulator into result register.
- `en_shift`  out  1  to all PEs: shift result chain one row toward the bottom edge.
- `r_in`  in  C*WY  bottom-row `ro` of each column; column c at bits [c*WY +: WY].
- `m_axis_tdata`  out  C*WY  equals `r_in`, passed through.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  final beat of a tile whose `s_last` was 1.
- `m_axis_tuser`  out  $clog2(R)  source row index of the beat; first beat is R-1.

## Operation
- States: IDLE, COPY, SHIFT.
- **IDLE**
  - `s_ready`=1.
  - `s_done`=1 → latch `s_last` into `last_q`, go to COPY.
- **COPY**
  - One cycle. `r_copy`=1, `s_ready`=0, `m_axis_tvalid`=0.
  - Always goes to SHIFT next cycle.
- **SHIFT**
  - `m_axis_tvalid`=1, `m_axis_tdata`=`r_in`.
  - `en_shift` = `m_axis_tvalid & m_axis_tready`. This is combinational, so the chain advances exactly on each accepted beat.
  - Beat counter `beat_q` runs 0..R-1 and increments per accepted beat.
  - `m_axis_tuser` = R-1-`beat_q`.
  - `m_axis_tlast` = `last_q & (beat_q==R-1)`.
  - Accepted beat with `beat_q==R-1` → IDLE, `beat_q`←0.
- `r_copy` and `en_shift` are never high in the same cycle.
- `s_done` while `s_ready`=0 is ignored; the array controller must not issue it.
- `tdata`, `tuser` and `tlast` are held stable while `tvalid & !tready`. `tdata` stays stable because `en_shift` is low, so `r_in` does not change.
- Reset, including mid-drain:
  - state=IDLE, `beat_q`=0, `last_q`=0.
  - All outputs 0 except `s_ready`=1. Outputs are decoded from state, so they reach these values in the cycle after the reset edge.
  - Partial tile contents still in the PEs are abandoned; the next COPY overwrites them.
- Widths: `beat_q` and `tuser` are $clog2(R) bits. R=1 uses a 1-bit counter and `tuser`=0.

## Timing
- Cycle T: `s_done`=1 in IDLE.
- Cycle T+1: `r_copy`=1. PEs load on the edge ending T+1.
- Cycle T+2: first beat valid (row R-1). Minimum latency from `s_done` to first `tvalid` is 2 cycles.
- With `tready` held high: R consecutive beats in T+2..T+R+1, and `s_ready`=1 at T+R+2.
- Back-to-back tiles: the next `s_done` can arrive at T+R+2. Per-tile overhead is 2 cycles (IDLE accept + COPY).
- Data dependency: `r_in` in the cycle after an accepted beat is the next row up, because PE `ro` updates on the same edge that `en_shift` is sampled.

## Structure
- Shared `sa_pkg` holds:
  - `drain_state_t` enum (IDLE, COPY, SHIFT);
  - a `ROW_W(R)` localparam helper for `$clog2` with an R=1 guard.
- Single module with no sub-modules: state register, beat counter, `last_q` flag and output decode.

## Test plan
- **Basic drain** (R=4, C=2, WY=16, `tready`=1, chain preloaded so rows 3..0 carry {0x0301,0x0300}..{0x0001,0x0000}, `s_last`=1):
  - 4 beats in row order 3,2,1,0, with `tuser`=3,2,1,0;
  - `tlast` only on beat 4;
  - `r_copy` high exactly 1 cycle, `en_shift` high 4 cycles.
- **Backpressure**: `tready` toggled 1,0,0,1,0,1,1.
  - `tdata`/`tuser` held during stalls; `en_shift`=0 whenever `tready`=0.
  - Exactly 4 beats accepted, no duplicates or drops.
- **Back-to-back tiles**: `s_done` with `s_last`=0, then `s_done` with `s_last`=1 asserted the first cycle `s_ready` returns.
  - 8 beats; `tlast` only on beat 8; 2-cycle gap between tiles.
- **Ignored done**: `s_done` pulsed during SHIFT → no extra `r_copy`, beat count unchanged.
- **Reset mid-drain**: `rst` after beat 2.
  - Next cycle `tvalid`=0, `s_ready`=1.
  - A fresh `s_done` yields 4 full beats starting at `tuser`=3.
- **R=1 edge case**: one beat per tile, `tuser`=0, `tlast`=`s_last`.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared systolic-array types: drain FSM states and the row-index width helper.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        SHIFT
    } drain_state_t;

    // $clog2(1) is 0, which would give zero-width row indices; keep at least one bit.
    function automatic int ROW_W(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/sa_drain.sv
// Output drain for the systolic array: one result-copy strobe per tile, then walks
// the PE result chain bottom row first and emits each row as an AXI-Stream beat.
module sa_drain
    import sa_pkg::*;
#(
    parameter int R  = 4,
    parameter int C  = 4,
    parameter int WY = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_done,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 r_copy,
    output logic                 en_shift,
    input  logic [C*WY-1:0]      r_in,
    output logic [C*WY-1:0]      m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [ROW_W(R)-1:0]  m_axis_tuser
);

    localparam int            RW        = ROW_W(R);
    localparam logic [RW-1:0] LAST_BEAT = RW'(R - 1);

    drain_state_t  state_q, state_d;
    logic [RW-1:0] beat_q;
    logic          last_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && s_done) begin
                last_q <= s_last;
            end
            if (en_shift) begin
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + RW'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        s_ready       = 1'b0;
        r_copy        = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_done) begin
                    state_d = COPY;
                end
            end
            COPY: begin
                r_copy  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tuser  = LAST_BEAT - beat_q;
                m_axis_tlast  = last_q && (beat_q == LAST_BEAT);
                if (m_axis_tready && beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The chain only moves on an accepted beat, so r_in (and thus tdata) is frozen while stalled.
    assign en_shift     = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata = r_in;

endmodule
